// File: rtl/spi_tft_writer_if.sv
// Frame-control, pixel-fetch and SPI pin bundle for spi_tft_writer.
// master = the writer itself; slave = the framebuffer / TFT side.
interface spi_tft_writer_if;
  logic       frame_start;
  logic       busy;
  logic       frame_done;
  logic [7:0] pixel_x;
  logic [5:0] pixel_y;
  logic       pixel_req;
  logic       pixel;
  logic       spi_clk;
  logic       spi_di;
  logic       spi_dc;
  logic       spi_cs;

  modport master (
    input  frame_start, pixel,
    output busy, frame_done, pixel_x, pixel_y, pixel_req,
           spi_clk, spi_di, spi_dc, spi_cs
  );

  modport slave (
    output frame_start, pixel,
    input  busy, frame_done, pixel_x, pixel_y, pixel_req,
           spi_clk, spi_di, spi_dc, spi_cs
  );
endinterface

// File: rtl/spi_tft_writer.sv
// SPI initiator sending CASET/RASET/RAMWR then one RGB565 word per framebuffer bit.
// Optional macro SPI_TFT_MADCTL_EN prepends a MADCTL command and parameter byte.
module spi_tft_writer #(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned WIDTH        = 240,
  parameter int unsigned HEIGHT       = 64,
  parameter logic [15:0] FG_COLOR     = 16'hFFFF,
  parameter logic [15:0] BG_COLOR     = 16'h0000,
  parameter logic [7:0]  MADCTL_VALUE = 8'h00
) (
  input  logic               clk,
  input  logic               reset,
  spi_tft_writer_if.master   bus
);

  localparam int unsigned     DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [15:0]     COL_LAST = 16'(WIDTH - 1);
  localparam logic [15:0]     ROW_LAST = 16'(HEIGHT - 1);
  localparam logic [7:0]      X_LAST   = 8'(WIDTH - 1);
  localparam logic [5:0]      Y_LAST   = 6'(HEIGHT - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD_MADCTL,
    S_DAT_MADCTL,
    S_CMD_CASET,
    S_DAT_CASET,
    S_CMD_RASET,
    S_DAT_RASET,
    S_CMD_RAMWR,
    S_FETCH,
    S_LATCH,
    S_PIX_HI,
    S_PIX_LO,
    S_TAIL
  } state_t;

`ifdef SPI_TFT_MADCTL_EN
  localparam state_t     FIRST_STATE = S_CMD_MADCTL;
  localparam logic [7:0] FIRST_BYTE  = 8'h36;
`else
  localparam state_t     FIRST_STATE = S_CMD_CASET;
  localparam logic [7:0] FIRST_BYTE  = 8'h2A;
`endif

  // Address-window parameter bytes: start is always 0, end is split MSB/LSB.
  function automatic logic [7:0] param_byte(input logic [1:0] idx, input logic [15:0] last);
    case (idx)
      2'd2:    return last[15:8];
      2'd3:    return last[7:0];
      default: return 8'h00;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [7:0]       sh_q, sh_d;
  logic [2:0]       bit_q, bit_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             sck_q, sck_d;
  logic             dc_q, dc_d;
  logic             cs_q, cs_d;
  logic             done_q, done_d;
  logic [1:0]       idx_q, idx_d;
  logic [7:0]       x_q, x_d;
  logic [5:0]       y_q, y_d;
  logic [15:0]      word_q, word_d;

  logic             byte_end;
  logic             load;
  logic [7:0]       load_byte;
  logic             load_dc;

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    bit_d     = bit_q;
    div_d     = div_q;
    sck_d     = sck_q;
    dc_d      = dc_q;
    cs_d      = cs_q;
    done_d    = 1'b0;
    idx_d     = idx_q;
    x_d       = x_q;
    y_d       = y_q;
    word_d    = word_q;
    byte_end  = 1'b0;
    load      = 1'b0;
    load_byte = '0;
    load_dc   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cs_d  = 1'b1;
        sck_d = 1'b0;
        dc_d  = 1'b0;
        sh_d  = '0;
        div_d = '0;
        bit_d = '0;
        x_d   = '0;
        y_d   = '0;
        if (bus.frame_start) begin
          load      = 1'b1;
          load_byte = FIRST_BYTE;
          load_dc   = 1'b0;
          idx_d     = '0;
          state_d   = FIRST_STATE;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        word_d    = bus.pixel ? FG_COLOR : BG_COLOR;
        load      = 1'b1;
        load_byte = word_d[15:8];
        load_dc   = 1'b1;
        state_d   = S_PIX_HI;
      end
      S_TAIL: begin
        if (div_q == DIV_LAST) begin
          state_d = S_IDLE;
          cs_d    = 1'b1;
          dc_d    = 1'b0;
          done_d  = 1'b1;
          div_d   = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: begin
        // Every remaining state shifts one byte: CLK_DIV low, CLK_DIV high per bit.
        if (div_q != DIV_LAST) begin
          div_d = div_q + 1'b1;
        end else if (!sck_q) begin
          div_d = '0;
          sck_d = 1'b1;
        end else if (bit_q != 3'd7) begin
          div_d = '0;
          sck_d = 1'b0;
          bit_d = bit_q + 1'b1;
          sh_d  = {sh_q[6:0], 1'b0};
        end else begin
          byte_end = 1'b1;
        end
      end
    endcase

    if (byte_end) begin
      sck_d = 1'b0;
      div_d = '0;
      sh_d  = '0;
      case (state_q)
        S_CMD_MADCTL: begin
          load = 1'b1; load_byte = MADCTL_VALUE; load_dc = 1'b1; state_d = S_DAT_MADCTL;
        end
        S_DAT_MADCTL: begin
          load = 1'b1; load_byte = 8'h2A; load_dc = 1'b0; state_d = S_CMD_CASET;
        end
        S_CMD_CASET: begin
          load = 1'b1; load_byte = param_byte(2'd0, COL_LAST); load_dc = 1'b1;
          idx_d = '0; state_d = S_DAT_CASET;
        end
        S_DAT_CASET: begin
          load = 1'b1;
          if (idx_q == 2'd3) begin
            load_byte = 8'h2B; load_dc = 1'b0; state_d = S_CMD_RASET;
          end else begin
            idx_d = idx_q + 2'd1; load_byte = param_byte(idx_q + 2'd1, COL_LAST); load_dc = 1'b1;
          end
        end
        S_CMD_RASET: begin
          load = 1'b1; load_byte = param_byte(2'd0, ROW_LAST); load_dc = 1'b1;
          idx_d = '0; state_d = S_DAT_RASET;
        end
        S_DAT_RASET: begin
          load = 1'b1;
          if (idx_q == 2'd3) begin
            load_byte = 8'h2C; load_dc = 1'b0; state_d = S_CMD_RAMWR;
          end else begin
            idx_d = idx_q + 2'd1; load_byte = param_byte(idx_q + 2'd1, ROW_LAST); load_dc = 1'b1;
          end
        end
        S_CMD_RAMWR: state_d = S_FETCH;
        S_PIX_HI: begin
          load = 1'b1; load_byte = word_q[7:0]; load_dc = 1'b1; state_d = S_PIX_LO;
        end
        S_PIX_LO: begin
          if (x_q == X_LAST && y_q == Y_LAST) begin
            state_d = S_TAIL;
          end else begin
            state_d = S_FETCH;
            if (x_q == X_LAST) begin
              x_d = '0;
              y_d = y_q + 6'd1;
            end else begin
              x_d = x_q + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end

    if (load) begin
      sh_d  = load_byte;
      dc_d  = load_dc;
      bit_d = '0;
      div_d = '0;
      sck_d = 1'b0;
      cs_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      sck_q   <= 1'b0;
      dc_q    <= 1'b0;
      cs_q    <= 1'b1;
      done_q  <= 1'b0;
      idx_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      sck_q   <= sck_d;
      dc_q    <= dc_d;
      cs_q    <= cs_d;
      done_q  <= done_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      y_q     <= y_d;
      word_q  <= word_d;
    end
  end

  assign bus.busy       = (state_q != S_IDLE);
  assign bus.frame_done = done_q;
  assign bus.pixel_req  = (state_q == S_FETCH);
  assign bus.pixel_x    = x_q;
  assign bus.pixel_y    = y_q;
  assign bus.spi_clk    = sck_q;
  assign bus.spi_di     = sh_q[7];
  assign bus.spi_dc     = dc_q;
  assign bus.spi_cs     = cs_q;

endmodule
